btn_cond: RTL

Input conditioner producing the single-cycle `button`, `u_button` and `d_button` strobes consumed by the mode-select FSM, from three raw, bouncing, asynchronous push-button pins. Each channel is synchronized and debounced, and a one-cycle pulse is emitted per press. The up and down channels auto-repeat while held, for address browsing in the DATA_OUT mode. The block sits between the board pins and the mode/control logic, in the same clock domain as the CPU.

---
 rtl/btn_cond.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/btn_cond.sv
// -----------------------------------------------------------------------------
// btn_cond
//   Conditions three raw, bouncing, asynchronous push-button pins into
//   single-cycle press strobes for the mode-select FSM. Each channel is
//   synchronized with two flops and debounced. A debounced 0->1 transition
//   emits one strobe. The up and down channels auto-repeat while held.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-low reset (release is synchronous upstream)
//   raw_btn    in   raw center button, active-high, asynchronous
//   raw_up     in   raw up button, active-high, asynchronous
//   raw_dn     in   raw down button, active-high, asynchronous
//   button     out  one-cycle center press strobe (never repeats)
//   u_button   out  one-cycle up press / auto-repeat strobe
//   d_button   out  one-cycle down press / auto-repeat strobe
//   btn_level  out  debounced levels {dn, up, btn}
// -----------------------------------------------------------------------------
module btn_cond #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 20_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_btn,
  input  logic       raw_up,
  input  logic       raw_dn,
  output logic       button,
  output logic       u_button,
  output logic       d_button,
  output logic [2:0] btn_level
);

  // Counter widths are just wide enough for the largest value each counter holds
  // (DEBOUNCE_CYCLES-1, and max(REPEAT_DELAY, REPEAT_RATE)-1).
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RP_W    = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

  localparam logic [DB_W-1:0] DB_ZERO    = DB_W'(32'd0);
  localparam logic [DB_W-1:0] DB_ONE     = DB_W'(32'd1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 32'sd1);
  localparam logic [RP_W-1:0] RP_ZERO    = RP_W'(32'd0);
  localparam logic [RP_W-1:0] RP_ONE     = RP_W'(32'd1);
  localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 32'sd1);
  localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 32'sd1);

  // Channel order everywhere: [0] center, [1] up, [2] down.
  logic [2:0]            raw_s;
  logic [2:0]            meta_q;
  logic [2:0]            sync_q;
  logic [2:0]            level_q;
  logic [2:0]            level_d;
  logic [2:0][DB_W-1:0]  db_cnt_q;
  logic [2:0][DB_W-1:0]  db_cnt_d;
  logic [2:0]            press_s;

  // Repeat state, [0] up, [1] down. rp_rate_q is set once the first
  // (REPEAT_DELAY) interval has elapsed, so later intervals use REPEAT_RATE.
  logic [1:0][RP_W-1:0]  rp_cnt_q;
  logic [1:0][RP_W-1:0]  rp_cnt_d;
  logic [1:0]            rp_rate_q;
  logic [1:0]            rp_rate_d;
  logic [1:0]            rp_fire_s;
  logic                  both_s;

  logic                  button_q;
  logic                  button_d;
  logic                  u_button_q;
  logic                  u_button_d;
  logic                  d_button_q;
  logic                  d_button_d;

  assign raw_s = {raw_dn, raw_up, raw_btn};

  // Debounce: count consecutive mismatches between sync and level; toggle on the last one.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = {3{DB_ZERO}};
    press_s  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (sync_q[i] != level_q[i]) begin
        if (db_cnt_q[i] >= DB_LAST) begin
          level_d[i]  = ~level_q[i];
          db_cnt_d[i] = DB_ZERO;
          press_s[i]  = ~level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
        end
      end else begin
        db_cnt_d[i] = DB_ZERO;
      end
    end
  end

  assign both_s = level_q[1] & level_q[2];

  // Auto-repeat timers for up/down. The counter is held at zero while the level is low,
  // on the edge the level falls (so no strobe appears alongside a low level), and while
  // both up and down are held; releasing one of them therefore restarts the full delay.
  always_comb begin
    rp_cnt_d  = {2{RP_ZERO}};
    rp_rate_d = 2'b00;
    rp_fire_s = 2'b00;
    for (int j = 0; j < 2; j++) begin
      if (!level_q[j + 1] || !level_d[j + 1] || both_s) begin
        rp_cnt_d[j]  = RP_ZERO;
        rp_rate_d[j] = 1'b0;
      end else if (rp_cnt_q[j] >= (rp_rate_q[j] ? RATE_LAST : DELAY_LAST)) begin
        rp_cnt_d[j]  = RP_ZERO;
        rp_rate_d[j] = 1'b1;
        rp_fire_s[j] = 1'b1;
      end else begin
        rp_cnt_d[j]  = rp_cnt_q[j] + RP_ONE;
        rp_rate_d[j] = rp_rate_q[j];
      end
    end
  end

  // Strobe selection: up wins any same-cycle collision and the down event is dropped.
  always_comb begin
    button_d   = press_s[0];
    u_button_d = press_s[1] | rp_fire_s[0];
    d_button_d = (press_s[2] | rp_fire_s[1]) & ~u_button_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q     <= 3'b000;
      sync_q     <= 3'b000;
      level_q    <= 3'b000;
      db_cnt_q   <= {3{DB_ZERO}};
      rp_cnt_q   <= {2{RP_ZERO}};
      rp_rate_q  <= 2'b00;
      button_q   <= 1'b0;
      u_button_q <= 1'b0;
      d_button_q <= 1'b0;
    end else begin
      meta_q     <= raw_s;
      sync_q     <= meta_q;
      level_q    <= level_d;
      db_cnt_q   <= db_cnt_d;
      rp_cnt_q   <= rp_cnt_d;
      rp_rate_q  <= rp_rate_d;
      button_q   <= button_d;
      u_button_q <= u_button_d;
      d_button_q <= d_button_d;
    end
  end

  assign button    = button_q;
  assign u_button  = u_button_q;
  assign d_button  = d_button_q;
  assign btn_level = level_q;

endmodule
